counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 1..32.
REQ-002 Parameter MAX_COUNT, default 2**WIDTH-1, terminal value after which the count wraps to 0; legal range 1..2**WIDTH-1.
REQ-003 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, synchronous active-low reset.
REQ-005 Port enable, input, 1 bit, count enable; active high.
REQ-006 Port out, output, WIDTH bits, current count value, driven directly from a register.

Function
REQ-007 The block SHALL be a synchronous up-counter: at each rising clk edge with rst=1 and enable=1, out SHALL take out+1.
REQ-008 When out==MAX_COUNT, rst=1 and enable=1 at a rising edge, out SHALL take 0 (wrap), with no idle cycle and no stall.
REQ-009 At a rising edge with rst=1 and enable=0, out SHALL hold its value.
REQ-010 Latency SHALL be one cycle: a change on enable affects out at the first rising edge at which it is sampled.
REQ-011 out SHALL never exceed MAX_COUNT after any reset.
REQ-012 Increment arithmetic SHALL be WIDTH bits wide, with no overflow beyond the wrap defined in REQ-008.
REQ-013 out SHALL be glitch-free, with no combinational path from any input to out.

Reset
REQ-014 At a rising edge with rst=0, out SHALL be set to 0 regardless of enable.
REQ-015 Reset SHALL take priority over counting, including a reset asserted mid-count or at the wrap point.
REQ-016 Counting SHALL resume from 0 at the first rising edge after rst returns to 1 with enable=1.
REQ-017 Before the first reset edge, out is undefined, and the bench SHALL NOT check out until then.

Configuration
REQ-018 Macro COUNTER_TC_EN: when defined, the block SHALL add output port tc (1 bit), combinationally asserted when out==MAX_COUNT and enable=1 and rst=1, flagging that a wrap occurs at the next edge.
REQ-019 Without COUNTER_TC_EN, port tc and its logic SHALL be absent, and the counting behaviour SHALL be identical.

Structure
REQ-020 A shared package counter_pkg SHALL hold the default-width constant (4) and a helper function computing the default MAX_COUNT for a given width.
REQ-021 The block SHALL be a single module with one register process plus next-state logic; no sub-module is required.
REQ-022 Elaboration SHALL fail with an error when MAX_COUNT > 2**WIDTH-1 or WIDTH < 1.

Verification
REQ-023 Hold rst=0 for 2 cycles with enable=X/0 -> out=0000 after the first edge.
REQ-024 Release rst (rst=1), set enable=1 for 10 edges -> out=1010; then set enable=0 for 11 edges -> out stays 1010.
REQ-025 Starting from 0 with enable=1, apply 16 edges -> out steps 0001..1111 then 0000 (wrap); with COUNTER_TC_EN defined, tc=1 only while out=1111.
REQ-026 With count at 0111 and enable=1, assert rst=0 for one edge -> out=0000 at that edge; deassert rst -> next edge out=0001.
REQ-027 With WIDTH=4 and MAX_COUNT=9, enable=1 for 10 edges from reset -> out sequence 1..9,0.
REQ-028 Build once with and once without COUNTER_TC_EN -> identical out traces for the same stimulus.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter block.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32'd4;

  // Largest value representable in `width` bits, saturating at 32 bits.
  function automatic logic [31:0] default_max_count(input int unsigned width);
    if (width >= 32'd32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/counter.sv
// Synchronous up-counter with programmable wrap value and synchronous active-low reset.
// Optional terminal-count flag output tc is built when COUNTER_TC_EN is defined.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter logic [31:0] MAX_COUNT = default_max_count(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] out
`ifdef COUNTER_TC_EN
  ,
  output logic             tc
`endif
);

  generate
    if ((WIDTH < 32'd1) || (WIDTH > 32'd32)) begin : g_bad_width
      $error("counter: WIDTH must be in 1..32");
    end else if ((MAX_COUNT < 32'd1) || (MAX_COUNT > default_max_count(WIDTH))) begin : g_bad_max
      $error("counter: MAX_COUNT must be in 1..2**WIDTH-1");
    end else begin : g_ok
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_W = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] next_s;

  // Next-count logic; >= keeps an out-of-range value from ever counting upward.
  always_comb begin
    next_s = count_r;
    if (enable) begin
      if (count_r >= MAX_W) begin
        next_s = {WIDTH{1'b0}};
      end else begin
        next_s = count_r + ONE_W;
      end
    end else begin
      next_s = count_r;
    end
  end

  // Count register with synchronous reset taking priority over counting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= next_s;
    end
  end

  assign out = count_r;

`ifdef COUNTER_TC_EN
  assign tc = (count_r == MAX_W) && enable && rst;
`endif

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed scenarios plus randomized traffic vs. a modulo model.
module tb_counter;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] out_a;
  logic [3:0] out_b;
`ifdef COUNTER_TC_EN
  logic       tc_a;
  logic       tc_b;
`endif

  counter u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .out    (out_a)
`ifdef COUNTER_TC_EN
    ,
    .tc     (tc_a)
`endif
  );

  counter #(.WIDTH(4), .MAX_COUNT(32'd9)) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .out    (out_b)
`ifdef COUNTER_TC_EN
    ,
    .tc     (tc_b)
`endif
  );

  always #5 clk = ~clk;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int unsigned m_a     = 0;
  int unsigned m_b     = 0;
  bit          armed   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a modulo-(max+1) counter, cleared by reset, frozen when disabled.
  function automatic int unsigned model_next(int unsigned m, int unsigned maxc, logic r, logic e);
    if (r !== 1'b1) return 0;
    if (e === 1'b1) return (m + 1) % (maxc + 1);
    return m;
  endfunction

  task automatic step(input logic r, input logic e);
    @(negedge clk);
    rst    = r;
    enable = e;
`ifdef COUNTER_TC_EN
    #1;
    if (armed) begin
      check("tc_a", 32'(tc_a), 32'((m_a == 15) && (e === 1'b1) && (r === 1'b1)));
      check("tc_b", 32'(tc_b), 32'((m_b == 9) && (e === 1'b1) && (r === 1'b1)));
    end
`endif
    @(posedge clk);
    #1;
    m_a = model_next(m_a, 15, r, e);
    m_b = model_next(m_b, 9, r, e);
    if (r !== 1'b1) armed = 1'b1;
    if (armed) begin
      check("out_a", 32'(out_a), m_a);
      check("out_b", 32'(out_b), m_b);
    end
  endtask

  initial begin
    // Reset held for two edges, enable unknown then low.
    step(1'b0, 1'bx);
    check("rst_first_edge", 32'(out_a), 32'd0);
    step(1'b0, 1'b0);

    // Ten counting edges, then eleven holding edges.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      if (i == 8) check("b_reaches_9", 32'(out_b), 32'd9);
    end
    check("a_count_10", 32'(out_a), 32'd10);
    check("b_wraps_0", 32'(out_b), 32'd0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
    check("a_hold_10", 32'(out_a), 32'd10);

    // Full 16-edge lap from zero on the default instance.
    step(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1);
      if (i == 14) check("a_at_max", 32'(out_a), 32'd15);
    end
    check("a_wrap_0", 32'(out_a), 32'd0);

    // Reset in mid-count, then resume.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    check("a_at_7", 32'(out_a), 32'd7);
    step(1'b0, 1'b1);
    check("a_mid_reset", 32'(out_a), 32'd0);
    step(1'b1, 1'b1);
    check("a_resume_1", 32'(out_a), 32'd1);

    // Reset exactly at the wrap point.
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
    check("a_pre_wrap", 32'(out_a), 32'd15);
    step(1'b0, 1'b1);
    check("a_reset_at_wrap", 32'(out_a), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) != 0) ? 1'b1 : 1'b0, $urandom_range(3) != 0 ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
